// File: rtl/vector_hazard_ctrl.sv
// Issue-side hazard controller for the vector pipeline: a latency-indexed
// write-back scoreboard that produces issue stalls and registered forward selects.
module vector_hazard_ctrl #(
    parameter int MAX_LAT = 8,
    parameter int LW      = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          issue_valid_i,
    output logic          issue_ready_o,
    input  logic [4:0]    vs1_i,
    input  logic [4:0]    vs2_i,
    input  logic [4:0]    vd_i,
    input  logic          use_vs1_i,
    input  logic          use_vs2_i,
    input  logic          wr_vd_i,
    input  logic [LW-1:0] lat_i,
    output logic          fwd_a_o,
    output logic          fwd_b_o,
    output logic          wb_valid_o,
    output logic [4:0]    wb_vd_o,
    output logic [LW-1:0] inflight_o
);

    logic [MAX_LAT-1:0] slot_valid;
    logic [4:0]         slot_vd [MAX_LAT];
    logic [LW-1:0]      lat_l;
    logic               raw_hit;
    logic               port_hit;
    logic               waw_hit;
    logic               accept;

    always_comb begin
        if (lat_i < LW'(2))
            lat_l = LW'(2);
        else if (lat_i > LW'(MAX_LAT))
            lat_l = LW'(MAX_LAT);
        else
            lat_l = lat_i;
    end

    // Slot 0 writes through the VRF this edge, so only d >= 2 can cause RAW;
    // lat_l == MAX_LAT never indexes a real slot, so port/WAW vanish there.
    always_comb begin
        raw_hit  = 1'b0;
        port_hit = 1'b0;
        waw_hit  = 1'b0;
        for (int d = 0; d < MAX_LAT; d++) begin
            if (slot_valid[d]) begin
                if (d >= 2 && ((use_vs1_i && slot_vd[d] == vs1_i) ||
                               (use_vs2_i && slot_vd[d] == vs2_i)))
                    raw_hit = 1'b1;
                if (wr_vd_i && d == int'(lat_l))
                    port_hit = 1'b1;
                if (wr_vd_i && d >= int'(lat_l) && slot_vd[d] == vd_i)
                    waw_hit = 1'b1;
            end
        end
    end

    assign issue_ready_o = ~rst_i & ~flush_i & ~(raw_hit | port_hit | waw_hit);
    assign accept        = issue_valid_i & issue_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            slot_valid <= '0;
            for (int d = 0; d < MAX_LAT; d++)
                slot_vd[d] <= '0;
            fwd_a_o <= 1'b0;
            fwd_b_o <= 1'b0;
        end else begin
            for (int d = 0; d < MAX_LAT - 1; d++) begin
                slot_valid[d] <= slot_valid[d+1];
                slot_vd[d]    <= slot_vd[d+1];
            end
            slot_valid[MAX_LAT-1] <= 1'b0;
            slot_vd[MAX_LAT-1]    <= '0;
            // Port-conflict check guarantees the target slot arrives empty.
            for (int d = 0; d < MAX_LAT; d++) begin
                if (accept && wr_vd_i && d == int'(lat_l) - 1) begin
                    slot_valid[d] <= 1'b1;
                    slot_vd[d]    <= vd_i;
                end
            end
            fwd_a_o <= accept & use_vs1_i & slot_valid[1] & (slot_vd[1] == vs1_i);
            fwd_b_o <= accept & use_vs2_i & slot_valid[1] & (slot_vd[1] == vs2_i);
        end
    end

    always_comb begin
        inflight_o = '0;
        for (int d = 0; d < MAX_LAT; d++)
            inflight_o = inflight_o + LW'(slot_valid[d]);
    end

    assign wb_valid_o = slot_valid[0];
    assign wb_vd_o    = slot_vd[0];

endmodule
